// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration controller.
// Contents: DIV_W (rPLL divider-select width), state_e (controller FSM states).
package pll_ctrl_pkg;

  localparam int DIV_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT_RST = 2'd1,
    ST_WAIT_LOCK  = 2'd2,
    ST_SETTLE     = 2'd3
  } state_e;

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Request channel into the PLL reconfiguration controller.
//   req_valid              : requester has new divider selects
//   req_ready              : controller can accept (IDLE only)
//   req_fbdsel/idsel/odsel : requested rPLL divider selects, raw encoding
// master = requester side, slave = controller side.
interface pll_reconfig_ctrl_if;
  logic                            req_valid;
  logic                            req_ready;
  logic [pll_ctrl_pkg::DIV_W-1:0]  req_fbdsel;
  logic [pll_ctrl_pkg::DIV_W-1:0]  req_idsel;
  logic [pll_ctrl_pkg::DIV_W-1:0]  req_odsel;

  modport master (output req_valid, req_fbdsel, req_idsel, req_odsel, input req_ready);
  modport slave  (input req_valid, req_fbdsel, req_idsel, req_odsel, output req_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output, 2-cycle latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL reconfiguration / lock-qualification controller.
// Runs reset -> wait-for-lock -> settle sequences on the rPLL, with timeout
// and bounded retries, and accepts new divider selects through `req`.
// Ports:
//   clk, rst_n            : board oscillator clock, async active-low reset
//   req (slave)           : request channel (valid/ready + divider selects)
//   pll_lock              : rPLL LOCK, asynchronous, synchronized internally
//   pll_reset             : rPLL RESET
//   pll_fbdsel/idsel/odsel: rPLL divider selects
//   locked, busy, done, error : status (done is a one-cycle pulse, error sticky)
// Build option: define PLL_AUTORELOCK_EN to relock automatically when lock
// is lost in IDLE; otherwise loss of lock raises error and waits for a request.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int               RESET_CYCLES  = 16,
  parameter int               LOCK_TIMEOUT  = 65535,
  parameter int               SETTLE_CYCLES = 256,
  parameter int               MAX_RETRIES   = 3,
  parameter logic [DIV_W-1:0] DEF_FBDSEL    = 6'd0,
  parameter logic [DIV_W-1:0] DEF_IDSEL     = 6'd0,
  parameter logic [DIV_W-1:0] DEF_ODSEL     = 6'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  pll_reconfig_ctrl_if.slave  req,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [DIV_W-1:0]    pll_fbdsel,
  output logic [DIV_W-1:0]    pll_idsel,
  output logic [DIV_W-1:0]    pll_odsel,
  output logic                locked,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int RW  = $clog2(RESET_CYCLES) + 1;
  localparam int TW  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW  = $clog2(SETTLE_CYCLES) + 1;
  localparam int RTW = $clog2(MAX_RETRIES) + 1;

  state_e           state_q;
  logic [RW-1:0]    rst_cnt_q;
  logic [TW-1:0]    to_cnt_q;
  logic [SW-1:0]    set_cnt_q;
  logic [RTW-1:0]   retry_q;
  logic [DIV_W-1:0] fb_q, id_q, od_q;
  logic             pll_reset_q, locked_q, busy_q, done_q, error_q, ready_q;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Reset lands directly in ASSERT_RST so a full lock sequence runs on
  // power-up; busy/ready are registered alongside every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT_RST;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      set_cnt_q   <= '0;
      retry_q     <= '0;
      fb_q        <= DEF_FBDSEL;
      id_q        <= DEF_IDSEL;
      od_q        <= DEF_ODSEL;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A request wins over a simultaneous loss-of-lock detection.
          if (req.req_valid && ready_q) begin
            fb_q        <= req.req_fbdsel;
            id_q        <= req.req_idsel;
            od_q        <= req.req_odsel;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
            retry_q     <= '0;
            rst_cnt_q   <= '0;
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= ST_ASSERT_RST;
          end else if (locked_q && !lock_s) begin
            locked_q <= 1'b0;
`ifdef PLL_AUTORELOCK_EN
            retry_q     <= '0;
            rst_cnt_q   <= '0;
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= ST_ASSERT_RST;
`else
            error_q <= 1'b1;
`endif
          end
        end
        ST_ASSERT_RST: begin
          busy_q <= 1'b1;  // first cycle after rst_n release
          if (rst_cnt_q >= RW'(RESET_CYCLES - 1)) begin
            pll_reset_q <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= ST_WAIT_LOCK;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Timeout count persists across SETTLE bounces within one attempt.
          if (lock_s) begin
            set_cnt_q <= '0;
            state_q   <= ST_SETTLE;
          end else if (to_cnt_q >= TW'(LOCK_TIMEOUT)) begin
            if (retry_q < RTW'(MAX_RETRIES)) begin
              retry_q     <= retry_q + 1'b1;
              rst_cnt_q   <= '0;
              pll_reset_q <= 1'b1;
              state_q     <= ST_ASSERT_RST;
            end else begin
              error_q  <= 1'b1;
              locked_q <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
          end else if (set_cnt_q >= SW'(SETTLE_CYCLES - 1)) begin
            locked_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign pll_reset     = pll_reset_q;
  assign pll_fbdsel    = fb_q;
  assign pll_idsel     = id_q;
  assign pll_odsel     = od_q;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: PLL reset pulse width in clk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK cycles per attempt.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256: consecutive synced-lock-high cycles required to declare lock.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: extra attempts after the first timeout.
REQ-005 SHALL have parameters DEF_FBDSEL, DEF_IDSEL, DEF_ODSEL, default 6'd0: divider selects applied at reset.
REQ-006 SHALL have ports:
  clk  in  1  controller clock, the stable board oscillator, never the PLL output
  rst_n  in  1  asynchronous, active-low reset
  req_valid  in  1  reconfiguration request
  req_ready  out  1  request accepted when req_valid and req_ready are both high
  req_fbdsel, req_idsel, req_odsel  in  6 each  requested divider selects, raw encoding
  pll_lock  in  1  rPLL LOCK, asynchronous to clk
  pll_reset  out  1  drives rPLL RESET
  pll_fbdsel, pll_idsel, pll_odsel  out  6 each  drive rPLL FBDSEL/IDSEL/ODSEL
  locked  out  1  qualified lock status
  busy  out  1  high in any state other than IDLE
  done  out  1  one-cycle pulse at the end of each sequence
  error  out  1  sticky failure flag

Function
REQ-007 SHALL pass pll_lock through a 2-flop synchronizer; all lock decisions use the synced value (2-cycle latency).
REQ-008 SHALL implement states IDLE, ASSERT_RST, WAIT_LOCK, SETTLE.
REQ-009 SHALL drive req_ready high only in IDLE; on accept, SHALL latch the req_* values into pll_*sel, clear error, clear locked, zero the retry count, and enter ASSERT_RST on the next cycle.
REQ-010 SHALL hold pll_reset high for exactly RESET_CYCLES cycles in ASSERT_RST and low in all other states; pll_*sel SHALL be stable throughout.
REQ-011 In WAIT_LOCK, SHALL count cycles from 0; a synced lock high moves the FSM to SETTLE without resetting the timeout count.
REQ-012 In SETTLE, SETTLE_CYCLES consecutive high cycles SHALL set locked=1, pulse done, and enter IDLE; a low cycle SHALL return the FSM to WAIT_LOCK.
REQ-013 When the timeout count reaches LOCK_TIMEOUT: if retries < MAX_RETRIES, SHALL increment retries and re-enter ASSERT_RST; otherwise SHALL set error=1, keep locked=0, pulse done, and enter IDLE.
REQ-014 req_valid outside IDLE SHALL be ignored (no queuing); a request on the same cycle that loss-of-lock is detected in IDLE SHALL take priority.
REQ-015 In IDLE with locked=1, a synced lock low SHALL clear locked on the next cycle and trigger the behaviour in REQ-020/021.
REQ-016 Counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL saturate, never wrap.

Reset
REQ-017 While rst_n is low: pll_reset=1, pll_*sel=DEF_*, locked=0, busy=0, done=0, error=0, req_ready=0, and counters and synchronizer cleared.
REQ-018 After rst_n deasserts, SHALL enter ASSERT_RST with DEF_* and run a full lock sequence unprompted; busy=1.
REQ-019 rst_n asserted mid-sequence SHALL abort immediately to the reset values.

Configuration
REQ-020 With PLL_AUTORELOCK_EN defined, loss of lock in IDLE SHALL re-enter ASSERT_RST with the current pll_*sel and the retry count zeroed.
REQ-021 Without PLL_AUTORELOCK_EN, loss of lock SHALL set error=1 and remain in IDLE until a new request.

Structure
REQ-022 The package pll_ctrl_pkg SHALL hold the state enum and DIV_W=6.
REQ-023 The synchronizer SHALL be the sub-module sync_2ff.

Verification
REQ-024 Release reset with lock rising 100 cycles later -> pll_reset high for 16 cycles, then locked=1 and a done pulse 2+256 cycles after the lock rise.
REQ-025 Request fbdsel=21, idsel=0, odsel=2 in IDLE -> the pll_*sel outputs equal those values on the next cycle, and pll_reset pulses for 16 cycles.
REQ-026 Lock held low with LOCK_TIMEOUT=100 -> 4 reset pulses, then error=1, locked=0, and one done pulse.
REQ-027 Lock glitching low at SETTLE cycle 200 -> the FSM returns to WAIT_LOCK, and the settle count restarts at 0.
REQ-028 Lock dropping in IDLE -> with PLL_AUTORELOCK_EN, a relock sequence starts; without it, error=1 and busy stays 0.
REQ-029 rst_n pulsed low during WAIT_LOCK -> all outputs take their reset values asynchronously.
